// File: rtl/video_acc_pkg.sv
// Shared definitions for the video accelerator: opcodes, scheduler states and
// the opcode-to-router-destination map.
package video_acc_pkg;

  localparam logic [5:0] OP_MOV         = 6'h08;
  localparam logic [5:0] OP_DCT         = 6'h09;
  localparam logic [5:0] OP_IDCT        = 6'h0A;
  localparam logic [5:0] OP_CHROMA      = 6'h0B;
  localparam logic [5:0] META_PARAM_END = 6'h0C;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RUN
  } sched_state_t;

  typedef struct packed {
    logic       mapped;
    logic [7:0] dest;
  } op_dest_t;

  function automatic op_dest_t op_to_dest(input logic [5:0] op);
    op_dest_t res;
    res = '{mapped: 1'b0, dest: 8'd0};
    if (op >= OP_MOV && op < META_PARAM_END) begin
      res.mapped = 1'b1;
      res.dest   = 8'(op - OP_MOV);
    end
    return res;
  endfunction

endpackage

// File: rtl/video_mover_issue.sv
// Per-mover request latch: loads programming data, holds valid until the
// mover handshakes, then drops it. abort drops valid without a handshake.
module video_mover_issue #(
  parameter int WIDTH = 64
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             abort,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (abort || (valid && ready)) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/video_cmd_scheduler.sv
// Issues one decoded command at a time: route select, read/write mover issue,
// wait for both movers idle, retire. VIDEO_SCHED_TIMEOUT_EN adds a watchdog.
module video_cmd_scheduler
  import video_acc_pkg::*;
#(
  parameter int ADDR_WIDTH     = 64,
  parameter int DEST_WIDTH     = 3,
  parameter int NR_FUN_UNITS   = 2,
  parameter int BEAT_BYTES     = 8,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [5:0]            cmd_op,
  input  logic [ADDR_WIDTH-1:0] cmd_src,
  input  logic [ADDR_WIDTH-1:0] cmd_dest,
  input  logic [ADDR_WIDTH-1:0] cmd_len,
  output logic [ADDR_WIDTH-1:0] rd_src,
  output logic [ADDR_WIDTH-1:0] rd_len,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [ADDR_WIDTH-1:0] wr_dest,
  output logic                  wr_valid,
  input  logic                  wr_ready,
  output logic [DEST_WIDTH-1:0] route_dest,
  output logic                  busy,
  output logic [15:0]           done_count,
  output logic                  err,
  input  logic                  err_clr
);

  localparam logic [ADDR_WIDTH-1:0] BEAT = ADDR_WIDTH'(BEAT_BYTES);

  sched_state_t state, next_state;
  op_dest_t     dec;
  logic         accept, illegal, zero_len, load, retire, wd_expired;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign dec       = op_to_dest(cmd_op);
  assign illegal   = !dec.mapped || (int'(dec.dest) > NR_FUN_UNITS) ||
                     ((cmd_len % BEAT) != '0);
  assign zero_len  = (cmd_len == '0);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    // NOTE: every combinational output gets a default first, so no latch is inferred.
    next_state = state;
    load       = 1'b0;
    retire     = 1'b0;
    case (state)
      IDLE: begin
        if (accept && !illegal && !zero_len) begin
          load       = 1'b1;
          next_state = ISSUE;
        end
      end
      ISSUE: begin
        if (wd_expired)               next_state = IDLE;
        else if (!rd_valid && !wr_valid) next_state = RUN;
      end
      RUN: begin
        if (rd_ready && wr_ready) begin
          retire     = 1'b1;
          next_state = IDLE;
        end else if (wd_expired) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  video_mover_issue #(.WIDTH(2 * ADDR_WIDTH)) u_rd_issue (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .load      (load),
    .load_data ({cmd_src, cmd_len}),
    .abort     (wd_expired),
    .ready     (rd_ready),
    .valid     (rd_valid),
    .data      ({rd_src, rd_len})
  );

  video_mover_issue #(.WIDTH(ADDR_WIDTH)) u_wr_issue (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .load      (load),
    .load_data (cmd_dest),
    .abort     (wd_expired),
    .ready     (wr_ready),
    .valid     (wr_valid),
    .data      (wr_dest)
  );

  // A zero-length command retires straight from IDLE without mover traffic.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      route_dest <= '0;
      done_count <= '0;
      err        <= 1'b0;
    end else begin
      if (load) route_dest <= DEST_WIDTH'(dec.dest);
      if (retire || (accept && !illegal && zero_len)) done_count <= done_count + 16'd1;
      if ((accept && illegal) || wd_expired) err <= 1'b1;
      else if (err_clr)                      err <= 1'b0;
    end
  end

`ifdef VIDEO_SCHED_TIMEOUT_EN
  localparam logic [31:0] WD_LIMIT = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0] wd_cnt;

  // Counts busy cycles; fires on the TIMEOUT_CYCLES-th cycle after accept.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)  wd_cnt <= '0;
    else if (load) wd_cnt <= '0;
    else if (busy) wd_cnt <= wd_cnt + 32'd1;
  end

  assign wd_expired = busy && (wd_cnt == WD_LIMIT);
`else
  assign wd_expired = 1'b0;
`endif

endmodule

// File: doc/video_cmd_scheduler.md
Name: video_cmd_scheduler

Overview:
- Sequences one decoded accelerator command at a time onto the shared stream datapath.
- Selects the router destination (MOV or a function unit), then programs the DMA read mover (src/len) and write mover (dest) in parallel.
- Waits for both movers to return idle, then retires the command.
- Sits between the instruction decoder and the mover pair; it replaces the inline issue/wait logic in the accelerator top level.

Parameters:
- ADDR_WIDTH, 64, width of mover address and length fields.
- DEST_WIDTH, 3, width of router destination.
- NR_FUN_UNITS, 2, number of stream function units attached behind the router; legal destinations are 0..NR_FUN_UNITS.
- BEAT_BYTES, 8, mover beat size in bytes; len must be a multiple of this.
- TIMEOUT_CYCLES, 65535, watchdog limit (used only with the optional feature).

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  scheduler accepts command
- cmd_op  in  6  opcode: 8h MOV, 9h DCT, Ah IDCT, Bh CHROMA
- cmd_src  in  ADDR_WIDTH  absolute read address
- cmd_dest  in  ADDR_WIDTH  absolute write address
- cmd_len  in  ADDR_WIDTH  byte length
- rd_src, rd_len  out  ADDR_WIDTH  read mover programming
- rd_valid  out  1  read mover request
- rd_ready  in  1  read mover idle/accepting
- wr_dest  out  ADDR_WIDTH  write mover programming
- wr_valid  out  1  write mover request
- wr_ready  in  1  write mover idle/accepting
- route_dest  out  DEST_WIDTH  router destination for the current command
- busy  out  1  state != IDLE
- done_count  out  16  retired commands, wraps at FFFFh->0
- err  out  1  sticky error flag
- err_clr  in  1  clears err

Behaviour:
- Reset values:
  - All outputs are 0 except cmd_ready, which is 1.
  - State is IDLE.
- Clock and reset: aclk rising edge; asynchronous active-low reset aresetn. Reset mid-command drops all valids immediately and abandons the command.
- Opcode to destination map: MOV->0, DCT->1, IDCT->2, CHROMA->3.
- cmd_ready = (state == IDLE). A command is accepted on cmd_valid && cmd_ready.
- IDLE, on accept:
  - Reject the command if the opcode is unmapped, the destination is > NR_FUN_UNITS, or cmd_len % BEAT_BYTES != 0.
  - On reject: set err, stay in IDLE, do not count the command.
  - If cmd_len == 0: increment done_count and stay in IDLE. No mover traffic.
  - Otherwise: register rd_src, rd_len, wr_dest and route_dest; assert rd_valid=1 and wr_valid=1; go to ISSUE.
- ISSUE:
  - rd_valid drops the cycle after rd_valid && rd_ready; wr_valid likewise with its own handshake. The two handshakes are independent and may occur in any order or the same cycle.
  - Programming outputs are stable while the corresponding valid is high.
  - When both valids are low, go to RUN.
  - RUN is entered at the earliest 1 cycle after the last handshake. Mover contract: each mover deasserts ready the cycle after it accepts.
- RUN:
  - When rd_ready && wr_ready are both high: increment done_count and go to IDLE.
  - 1-cycle turnaround before cmd_ready reasserts.
- route_dest changes only on an accepted command in IDLE. It holds through ISSUE and RUN and after retirement.
- err: set by a reject (or timeout); cleared by err_clr. If set and clear occur in the same cycle, set wins.
- No command overlap; at most one command is in flight.

Optional Feature:
- Macro: VIDEO_SCHED_TIMEOUT_EN.
- With the macro defined:
  - A 32-bit watchdog counts cycles spent in ISSUE+RUN, resetting on each accept.
  - When it reaches TIMEOUT_CYCLES: set err, drop rd_valid/wr_valid, return to IDLE, do not increment done_count.
- Without the macro: no counter exists; the scheduler waits indefinitely.

Decomposition:
- Shared package video_acc_pkg holds:
  - opcode localparams (OP_MOV..OP_CHROMA, META_PARAM_END);
  - the state enum (IDLE/ISSUE/RUN);
  - the opcode-to-destination function.
- One natural sub-module: video_mover_issue, a per-mover valid/ready request latch (load, hold until handshake, drop). It is instantiated twice.

Test Plan:
- MOV src=1000h dest=2000h len=40h; both movers accept in cycle 1 and return ready after 10 cycles -> rd_src=1000h, rd_len=40h, wr_dest=2000h, route_dest=0; done_count=1; cmd_ready back after RUN exit.
- DCT with rd accepting 5 cycles after wr -> wr_valid drops first, rd_valid held with stable values; RUN entered only after both handshakes; route_dest=1 held throughout.
- Opcode 3Fh, then IDCT with len=44h -> err=1 for each, no valid asserted, done_count unchanged; err_clr then gives err=0.
- len=0 MOV -> done_count increments with no rd_valid/wr_valid pulse; busy stays 0.
- aresetn asserted in RUN -> all valids 0, busy=0, cmd_ready=1, route_dest=0 asynchronously.
- With VIDEO_SCHED_TIMEOUT_EN and TIMEOUT_CYCLES=100, mover never returns ready -> err=1 at cycle 100, state IDLE, done_count unchanged; without the macro, still busy at 1000 cycles.
